aplicador_volume: RTL and testbench
===================================

Name: aplicador_volume

Overview:
- Consumer end of the volume interface. Takes the BCD volume pair (volume1, volume0) and the mudou_volume strobe from the volume ASM, and validates the value as a level from 0 to 10.
- Ramps the applied level one step at a time so volume changes do not click.
- Gates the player's square-wave note through a PWM whose duty equals the applied level out of 10.
- Sits between the volume ASM and the audio output pin.

Parameters:
- PWM_PERIOD, 10, PWM counter modulus; duty = nivel/PWM_PERIOD; must be >= 10.
- RAMP_DIV, 4, clocks per ramp step; must be >= 1.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous reset, active-high.
- mudou_volume  in  1  single-cycle strobe: new volume is valid this cycle.
- volume1  in  4  BCD tens digit of the requested volume.
- volume0  in  4  BCD units digit of the requested volume.
- nota  in  1  square-wave note from the player.
- saida  out  1  registered PWM-modulated audio output.
- nivel  out  4  currently applied level, 0 to 10, binary.
- ocupado  out  1  high while in state RAMP.
- erro  out  1  one-cycle pulse when an invalid BCD value is strobed.

Behaviour:
- Reset: synchronous, dominates all other inputs. Next edge sets nivel=0, alvo=0, pwm_cnt=0, div=0, saida=0, ocupado=0, erro=0, state=IDLE.
- Capture: on an edge where mudou_volume=1, decode (volume1, volume0):
  - 0/0..0/9 gives alvo = volume0.
  - 1/0 gives alvo = 10.
  - Anything else: alvo is unchanged and erro=1 for exactly the next cycle.
  - When mudou_volume=0, erro=0.
- Mute needs no separate input: it arrives as a strobed 0/0.
- FSM, IDLE:
  - ocupado=0 and div is held at 0.
  - If alvo != nivel, go to RAMP at the next edge.
  - The earliest RAMP cycle is 2 cycles after the strobe cycle (1 edge to capture, 1 edge to transition).
- FSM, RAMP:
  - ocupado=1; div counts 0..RAMP_DIV-1.
  - On the edge where div==RAMP_DIV-1: nivel steps ±1 toward alvo and div returns to 0.
  - If the stepped nivel equals alvo, return to IDLE on that same edge.
  - If alvo changes mid-RAMP, the ramp continues from the current nivel toward the new alvo without resetting div.
  - If the new alvo equals the current nivel, return to IDLE at the next edge with div cleared and nivel not stepped.
  - nivel never leaves the range 0..10 and changes by at most 1 per step.
- Timing: a full step from 0 to 10 takes 10*RAMP_DIV cycles in RAMP.
- PWM:
  - pwm_cnt is free-running, 0..PWM_PERIOD-1, then wraps to 0.
  - saida(t+1) = nota(t) AND (pwm_cnt(t) < nivel(t)).
  - nivel=0 forces saida=0.
  - nivel=10 with PWM_PERIOD=10 makes saida follow nota delayed by 1 cycle.
- Simultaneous events:
  - A strobe during a step edge: the step uses the old alvo, and the new alvo is taken from the next cycle on.
  - A strobe with invalid BCD has no effect on alvo, nivel or state.

Decomposition:
- Shared package holds:
  - VOL_MAX=10, VOL_W=4, BCD_W=4.
  - State encoding IDLE/RAMP.
  - A BCD-pair validity/decode function.
- One natural sub-module: conversor_bcd_volume.
  - Combinational.
  - Inputs volume1, volume0; outputs nivel_bin[3:0] and valido.
- The ramp FSM, divider, PWM counter and output register live in the top module.

Test Plan:
- Reset, then strobe 0/5 with nota=1 held → ocupado rises 2 cycles after the strobe; nivel steps 1,2,3,4,5 every 4 cycles; ocupado low after the 5th step; saida high 5 of every 10 cycles.
- From nivel 5, strobe 1/0 then, before completion, strobe 0/7 → nivel climbs to 7 and stops; ocupado=0; nivel never exceeds 7.
- Strobe invalid 0/12 and 2/3 → erro pulses exactly 1 cycle each; nivel, alvo and ocupado unchanged.
- At nivel 10, strobe 0/0 (mute) → nivel descends 10..0 in 40 RAMP cycles; saida=0 from the cycle after nivel reaches 0.
- Assert reset mid-ramp at nivel 4 → next cycle nivel=0, ocupado=0, saida=0; no further steps until a new strobe.
- nivel=10, nota toggled → saida equals nota delayed by exactly 1 clock.

Source files
------------

// File: rtl/aplicador_volume_pkg.sv
// Shared definitions for the volume applier: level limits, FSM encoding and
// the BCD-pair decode used to validate a requested volume.
package aplicador_volume_pkg;

  localparam int VOL_MAX = 10;
  localparam int VOL_W   = 4;
  localparam int BCD_W   = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RAMP = 1'b1
  } estado_t;

  typedef struct packed {
    logic             valido;
    logic [VOL_W-1:0] nivel;
  } bcd_dec_t;

  // Only 00..09 and 10 are legal volume levels; everything else is rejected.
  function automatic bcd_dec_t bcd_decode(input logic [BCD_W-1:0] d1,
                                          input logic [BCD_W-1:0] d0);
    bcd_dec_t r;
    r.valido = 1'b0;
    r.nivel  = '0;
    if (d1 == '0 && d0 <= BCD_W'(9)) begin
      r.valido = 1'b1;
      r.nivel  = VOL_W'(d0);
    end else if (d1 == BCD_W'(1) && d0 == '0) begin
      r.valido = 1'b1;
      r.nivel  = VOL_W'(VOL_MAX);
    end
    return r;
  endfunction

endpackage

// File: rtl/aplicador_volume_conversor.sv
// Combinational BCD-pair to binary level converter with validity flag.
module conversor_bcd_volume
  import aplicador_volume_pkg::*;
(
  input  logic [3:0] volume1,
  input  logic [3:0] volume0,
  output logic [3:0] nivel_bin,
  output logic       valido
);

  bcd_dec_t dec;

  always_comb begin
    dec       = bcd_decode(volume1, volume0);
    nivel_bin = dec.nivel;
    valido    = dec.valido;
  end

endmodule

// File: rtl/aplicador_volume.sv
// Applies the strobed volume: ramps the level one step per RAMP_DIV clocks
// and gates the note through a PWM whose duty is nivel/PWM_PERIOD.
module aplicador_volume
  import aplicador_volume_pkg::*;
#(
  parameter int PWM_PERIOD = 10,
  parameter int RAMP_DIV   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mudou_volume,
  input  logic [3:0] volume1,
  input  logic [3:0] volume0,
  input  logic       nota,
  output logic       saida,
  output logic [3:0] nivel,
  output logic       ocupado,
  output logic       erro
);

  localparam int CNT_W = $clog2(PWM_PERIOD);
  localparam int DIV_W = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;

  logic [3:0] nivel_bin;
  logic       valido;

  conversor_bcd_volume u_conv (
    .volume1  (volume1),
    .volume0  (volume0),
    .nivel_bin(nivel_bin),
    .valido   (valido)
  );

  estado_t          state_q, state_d;
  logic [VOL_W-1:0] nivel_q, nivel_d;
  logic [VOL_W-1:0] alvo_q, alvo_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] pwm_cnt_q, pwm_cnt_d;
  logic             saida_q, saida_d;
  logic             ocupado_q, ocupado_d;
  logic             erro_q, erro_d;

  always_comb begin
    alvo_d = alvo_q;
    if (mudou_volume && valido) alvo_d = nivel_bin;
    erro_d = mudou_volume && !valido;

    // The ramp always compares against the registered target, so a strobe
    // landing on a step edge only takes effect from the following cycle.
    state_d = state_q;
    nivel_d = nivel_q;
    div_d   = div_q;
    case (state_q)
      IDLE: begin
        div_d = '0;
        if (alvo_q != nivel_q) state_d = RAMP;
      end
      RAMP: begin
        if (alvo_q == nivel_q) begin
          state_d = IDLE;
          div_d   = '0;
        end else if (div_q == DIV_W'(RAMP_DIV - 1)) begin
          div_d   = '0;
          nivel_d = (alvo_q > nivel_q) ? nivel_q + VOL_W'(1) : nivel_q - VOL_W'(1);
          if (nivel_d == alvo_q) state_d = IDLE;
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    ocupado_d = (state_d == RAMP);

    pwm_cnt_d = (pwm_cnt_q == CNT_W'(PWM_PERIOD - 1)) ? '0 : pwm_cnt_q + CNT_W'(1);
    saida_d   = nota && (pwm_cnt_q < CNT_W'(nivel_q));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      nivel_q   <= '0;
      alvo_q    <= '0;
      div_q     <= '0;
      pwm_cnt_q <= '0;
      saida_q   <= 1'b0;
      ocupado_q <= 1'b0;
      erro_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      nivel_q   <= nivel_d;
      alvo_q    <= alvo_d;
      div_q     <= div_d;
      pwm_cnt_q <= pwm_cnt_d;
      saida_q   <= saida_d;
      ocupado_q <= ocupado_d;
      erro_q    <= erro_d;
    end
  end

  assign saida   = saida_q;
  assign nivel   = nivel_q;
  assign ocupado = ocupado_q;
  assign erro    = erro_q;

endmodule

// File: tb/tb_aplicador_volume.sv
// Directed bench for aplicador_volume: ramp timing, retargeting, invalid BCD,
// mute, reset mid-ramp and full-duty pass-through.
module tb_aplicador_volume;

  logic       clk = 1'b0;
  logic       reset;
  logic       mudou_volume;
  logic [3:0] volume1;
  logic [3:0] volume0;
  logic       nota;
  logic       saida;
  logic [3:0] nivel;
  logic       ocupado;
  logic       erro;

  int total = 0;
  int bad   = 0;
  int cnt;
  int mx;
  logic [11:0] pat;

  aplicador_volume #(.PWM_PERIOD(10), .RAMP_DIV(4)) dut (
    .clk         (clk),
    .reset       (reset),
    .mudou_volume(mudou_volume),
    .volume1     (volume1),
    .volume0     (volume0),
    .nota        (nota),
    .saida       (saida),
    .nivel       (nivel),
    .ocupado     (ocupado),
    .erro        (erro)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Strobe lasts one cycle; returns at the negedge of the cycle after it.
  task automatic strobe(input logic [3:0] d1, input logic [3:0] d0);
    mudou_volume = 1'b1;
    volume1      = d1;
    volume0      = d0;
    tick();
    mudou_volume = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; mudou_volume = 1'b0; volume1 = '0; volume0 = '0; nota = 1'b0;
    tick(); tick();
    chk("rst_nivel", nivel, 0);
    chk("rst_ocupado", ocupado, 0);
    chk("rst_saida", saida, 0);
    chk("rst_erro", erro, 0);
    reset = 1'b0;
    tick();

    // Ramp 0 -> 5
    nota = 1'b1;
    strobe(4'd0, 4'd5);
    chk("t1_ocupado_c1", ocupado, 0);
    chk("t1_erro_valid", erro, 0);
    tick();
    chk("t1_ocupado_c2", ocupado, 1);
    chk("t1_nivel_c2", nivel, 0);
    for (int s = 1; s <= 5; s++) begin
      repeat (4) tick();
      chk($sformatf("t1_step%0d", s), nivel, s);
    end
    chk("t1_ocupado_end", ocupado, 0);
    tick();
    cnt = 0;
    repeat (10) begin
      tick();
      if (saida) cnt++;
    end
    chk("t1_duty5", cnt, 5);

    // Retarget 10 -> 7 mid-ramp
    strobe(4'd1, 4'd0);
    repeat (5) tick();
    chk("t2_nivel6", nivel, 6);
    strobe(4'd0, 4'd7);
    mx = 0;
    repeat (20) begin
      tick();
      if (int'(nivel) > mx) mx = int'(nivel);
    end
    chk("t2_max", mx, 7);
    chk("t2_nivel", nivel, 7);
    chk("t2_ocupado", ocupado, 0);

    // Invalid BCD values
    strobe(4'd0, 4'd12);
    chk("t3_erro_a", erro, 1);
    chk("t3_nivel_a", nivel, 7);
    chk("t3_ocupado_a", ocupado, 0);
    tick();
    chk("t3_erro_a_clr", erro, 0);
    strobe(4'd2, 4'd3);
    chk("t3_erro_b", erro, 1);
    tick();
    chk("t3_erro_b_clr", erro, 0);
    repeat (3) tick();
    chk("t3_ocupado_b", ocupado, 0);
    chk("t3_nivel_b", nivel, 7);

    // Up to 10, then full-duty pass-through
    strobe(4'd1, 4'd0);
    repeat (20) tick();
    chk("t4_nivel10", nivel, 10);
    chk("t4_ocupado", ocupado, 0);
    pat = 12'b1011_0011_1010;
    for (int i = 0; i < 12; i++) begin
      nota = pat[i];
      tick();
      chk($sformatf("t6_follow%0d", i), saida, pat[i]);
    end

    // Mute: 10 -> 0
    nota = 1'b1;
    strobe(4'd0, 4'd0);
    tick();
    chk("t4_mute_ocupado", ocupado, 1);
    chk("t4_mute_nivel10", nivel, 10);
    repeat (20) tick();
    chk("t4_mute_mid", nivel, 5);
    repeat (20) tick();
    chk("t4_mute_nivel0", nivel, 0);
    chk("t4_mute_ocupado_end", ocupado, 0);
    cnt = 0;
    repeat (12) begin
      tick();
      if (saida) cnt++;
    end
    chk("t4_mute_silent", cnt, 0);

    // Reset mid-ramp at level 4
    strobe(4'd0, 4'd9);
    repeat (17) tick();
    chk("t5_nivel4", nivel, 4);
    reset = 1'b1;
    tick();
    chk("t5_rst_nivel", nivel, 0);
    chk("t5_rst_ocupado", ocupado, 0);
    chk("t5_rst_saida", saida, 0);
    reset = 1'b0;
    repeat (30) tick();
    chk("t5_hold_nivel", nivel, 0);
    chk("t5_hold_ocupado", ocupado, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
